// File: rtl/instr_assembler.sv
// instr_assembler
// Packs decoded MIPS instruction fields back into 32-bit instruction words.
// Packed words are queued in a small circular FIFO and streamed out with a
// sequential PC tag. The test-program generator feeds it, and the
// instruction-memory loader writes out_instr at out_pc.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   flush               synchronous clear of FIFO and PC counter (err_cnt kept)
//   in_valid/in_ready   input tuple handshake
//   fmt                 0 = R, 1 = I, 2 = J, 3 = illegal (consumed, counted, dropped)
//   opcode..address     instruction fields
//   out_valid/out_ready output word handshake
//   out_instr, out_pc   head word and its PC
//   err_cnt             saturating count of dropped illegal tuples
//   level               FIFO occupancy
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its data until that edge; ready never depends on
// valid. in_ready is simply !full, so there is no pass-through when full.
// Flush wins over both transfers in the same cycle.
module instr_assembler #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_BASE = 32'h0000_3000,
  localparam int         AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    fmt,
  input  logic [5:0]    opcode,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [5:0]    funct,
  input  logic [15:0]   immediate,
  input  logic [25:0]   address,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [7:0]    err_cnt,
  output logic [AW:0]   level
);

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_q, pc_d;
  logic [7:0]    err_q, err_d;
  logic [31:0]   mem_q [DEPTH];

  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          legal;
  logic [31:0]   packed_word;

  always_comb begin
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    legal = (fmt != 2'd3);
    // A tuple offered during flush is dropped even though in_ready may be high.
    accept = in_valid && !full && !flush;
    push   = accept && legal;
    pop    = !empty && out_ready && !flush;
  end

  always_comb begin
    packed_word = 32'h0;
    case (fmt)
      FMT_R:   packed_word = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   packed_word = {opcode, rs, rt, immediate};
      FMT_J:   packed_word = {opcode, address};
      default: packed_word = 32'h0;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pc_d     = pc_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pc_d     = PC_BASE;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop) begin
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        pc_d     = pc_q + 32'd4;
      end
      if (accept && !legal && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pc_q     <= PC_BASE;
      err_q    <= 8'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= packed_word;
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_instr = empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
  assign out_pc    = pc_q;
  assign err_cnt   = err_q;
  assign level     = wr_ptr_q - rd_ptr_q;

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Packs decoded MIPS instruction fields (opcode, rs, rt, rd, shamt, funct, immediate, address) back into 32-bit instruction words. It is the encoding counterpart of the field splitter in the datapath. Packed words are buffered in a small FIFO and delivered over a valid/ready stream, each tagged with a sequential PC. The block sits between the test-program generator and instruction-memory load logic, which writes `out_instr` at `out_pc`.

## Interface
- `DEPTH`, 4: FIFO entries; a power of two, ≥ 2.
- `PC_BASE`, 32'h0000_3000: PC tagged on the first word after reset or flush.
- `clk` input 1: sole clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `flush` input 1: synchronous clear of FIFO contents and PC counter.
- `in_valid` input 1: field tuple on the inputs is valid.
- `in_ready` output 1: block can accept a tuple this cycle.
- `fmt` input 2: 0 = R, 1 = I, 2 = J, 3 = illegal.
- `opcode` input 6, `rs` input 5, `rt` input 5, `rd` input 5, `shamt` input 5, `funct` input 6: instruction fields.
- `immediate` input 16, `address` input 26: instruction fields.
- `out_valid` output 1: `out_instr`/`out_pc` hold a packed word.
- `out_ready` input 1: consumer takes the word this cycle.
- `out_instr` output 32: packed word at the FIFO head.
- `out_pc` output 32: PC of the head word.
- `err_cnt` output 8: count of illegal tuples dropped; saturating.
- `level` output log2(DEPTH)+1: current FIFO occupancy.

## Operation
- Input accept occurs when `in_valid && in_ready`. `in_ready` equals `!full`; there is no same-cycle pass-through when full.
- Packing, combinational before enqueue. Fields not listed for a format are ignored.
  - R: {opcode, rs, rt, rd, shamt, funct}
  - I: {opcode, rs, rt, immediate}
  - J: {opcode, address}
- An accepted tuple with `fmt`=3 is consumed (handshake completes) but is not enqueued. `err_cnt` increments and saturates at 255.
- Output pop occurs when `out_valid && out_ready`. On each pop the PC counter advances by 4 and wraps modulo 2^32.
- `out_pc` equals the PC counter, which is the PC of the current head word.
- FIFO is a circular buffer with read/write pointers one bit wider than log2(DEPTH).
  - Full: pointer MSBs differ and the low bits are equal.
  - Empty: pointers are equal.
- Push and pop in the same cycle (not full, not empty): `level` is unchanged and both pointers advance.
- When empty, `out_valid`=0 and `out_instr`=0. A pop is impossible.
- `flush` takes priority over push and pop in the same cycle.
  - Pointers and level go to 0; the PC counter goes to `PC_BASE`.
  - `err_cnt` is preserved.
  - A tuple presented in the flush cycle is dropped, even if `in_ready`=1.
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_instr`=0, `out_pc`=`PC_BASE`.
  - `err_cnt`=0, `level`=0.
  - FIFO storage need not be cleared.
- Reset asserted mid-stream discards all queued words immediately, without waiting for an edge.

## Timing
- Latency: a tuple accepted at edge N appears on `out_valid`/`out_instr` after edge N when the FIFO was empty. Input to output is 1 cycle.
- Throughput: one accept and one pop per cycle sustained, provided 0 < `level` < `DEPTH`.
- `in_ready` drops in the cycle after the accept that fills the FIFO. It rises in the cycle after the first pop from full.
- `out_instr`, `out_pc` and `out_valid` are stable while `out_valid && !out_ready`.
- `err_cnt` updates one edge after the illegal accept.
- `out_pc` updates one edge after the pop.

## Test plan
- R pack: fmt=0, opcode=0, rs=1, rt=2, rd=3, shamt=0, funct=0x21 → `out_instr`=0x00221821 and `out_pc`=0x00003000, one cycle after accept.
- I and J pack, back-to-back with `out_ready`=1:
  - ori: fmt=1, opcode=0x0D, rs=0, rt=1, imm=0x1234 → 0x34011234 at PC 0x3000.
  - j: fmt=2, opcode=2, address=0x0000C00 → 0x08000C00 at PC 0x3004.
- Full/backpressure: `out_ready`=0, push 5 tuples with DEPTH=4.
  - After 4 accepts, `level`=4 and `in_ready`=0; the 5th is held.
  - Assert `out_ready` for 1 cycle → `in_ready`=1 next cycle; the 5th is accepted with PC 0x3010.
- Illegal format: fmt=3 ×2, interleaved with one valid R tuple → `err_cnt`=2, `level`=1; no gap in PC sequence.
- Flush and simultaneous events: 3 queued words, then `flush` with `in_valid`=1 and `out_ready`=1.
  - Next cycle: `level`=0, `out_valid`=0, `out_pc`=0x3000, and `err_cnt` unchanged.
  - The next accepted word is tagged PC 0x3000.
- Async reset: assert `reset` between edges with 2 queued words → outputs reach their reset values before the next edge; `err_cnt`=0.
